// File: rtl/clock_ui_pkg.sv
// Shared encodings and default timing for the alarm-clock user interface.
package clock_ui_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    AL_HR   = 3'd3,
    AL_MIN  = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    OS_IDLE  = 2'd0,
    OS_PULSE = 2'd1,
    OS_HELD  = 2'd2
  } oneshot_t;

  localparam int DEF_HOLD_CYCLES    = 50_000_000;
  localparam int DEF_REPEAT_CYCLES  = 12_500_000;
  localparam int DEF_TIMEOUT_CYCLES = 500_000_000;

  // Successor of a mode when the mode button is pressed; stray codes fall back to RUN.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    nxt = RUN;
    case (cur)
      RUN:     nxt = SET_HR;
      SET_HR:  nxt = SET_MIN;
      SET_MIN: nxt = AL_HR;
      AL_HR:   nxt = AL_MIN;
      default: nxt = RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge one-shot: a single one-cycle pulse per press, however long the button is held.
module btn_pulse
  import clock_ui_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  oneshot_t state;

  // Pulse on the first sampled high, then wait in HELD until the button is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OS_IDLE;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        OS_IDLE: begin
          if (btn) begin
            state <= OS_PULSE;
            pulse <= 1'b1;
          end
        end
        OS_PULSE: state <= btn ? OS_HELD : OS_IDLE;
        OS_HELD:  if (!btn) state <= OS_IDLE;
        default:  state <= OS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock UI controller: mode FSM, field increment pulses, auto-repeat and edit timeout.
module clock_mode_ctrl
  import clock_ui_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  output logic [2:0] mode,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       inc_al_hr,
  output logic       inc_al_min,
  output logic       clock_run,
  output logic       alarm_en
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  mode_t         state;
  mode_t         nxt_state;
  logic          mode_pulse;
  logic          inc_pulse;
  logic          alarm_pulse;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic [IW-1:0] idle_cnt;
  logic          in_set;
  logic          timeout;
  logic          state_change;
  logic          rep_fire;
  logic          edit_fire;
  logic          hold_clr;
  logic          idle_clr;

  btn_pulse u_mode_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .pulse (mode_pulse)
  );

  btn_pulse u_inc_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .pulse (inc_pulse)
  );

  btn_pulse u_alarm_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_alarm),
    .pulse (alarm_pulse)
  );

  assign in_set = (state == SET_HR) || (state == SET_MIN) ||
                  (state == AL_HR)  || (state == AL_MIN);

  assign timeout = in_set && (idle_cnt == IDLE_LAST);

  assign rep_fire = in_set && btn_inc && (hold_cnt == HOLD_MAX) &&
                    ((rep_cnt == '0) || (rep_cnt == REP_MAX));

  assign state_change = (nxt_state != state);

  assign edit_fire = (inc_pulse || rep_fire) && in_set && !state_change;

  assign hold_clr = !btn_inc || !in_set || state_change || inc_pulse;

  assign idle_clr = state_change || !in_set || mode_pulse || inc_pulse ||
                    alarm_pulse || rep_fire;

  assign mode = state;

  // Mode button wins over timeout; RUN and any stray code settle back to RUN.
  always_comb begin
    nxt_state = state;
    if (mode_pulse) begin
      nxt_state = next_mode(state);
    end else if (timeout || !in_set) begin
      nxt_state = RUN;
    end
  end

  // Mode register plus registered field pulses, run enable and alarm arm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      inc_hr     <= 1'b0;
      inc_min    <= 1'b0;
      inc_al_hr  <= 1'b0;
      inc_al_min <= 1'b0;
      clock_run  <= 1'b1;
      alarm_en   <= 1'b0;
    end else begin
      state      <= nxt_state;
      inc_hr     <= edit_fire && (state == SET_HR);
      inc_min    <= edit_fire && (state == SET_MIN);
      inc_al_hr  <= edit_fire && (state == AL_HR);
      inc_al_min <= edit_fire && (state == AL_MIN);
      clock_run  <= !((nxt_state == SET_HR) || (nxt_state == SET_MIN));
      alarm_en   <= alarm_en ^ alarm_pulse;
    end
  end

  // Hold timer restarts at the press pulse, so the first repeat lands HOLD_CYCLES+1 after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Repeat spacing counter; zero means the first repeat has not fired yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (hold_clr) begin
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_cnt <= REP_ONE;
    end else if ((rep_cnt != '0) && (rep_cnt != REP_MAX)) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Inactivity counter for set modes; any button activity or mode entry restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (idle_clr) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl with short hold, repeat and timeout values.
module tb_clock_mode_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TMO  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_alarm;
  logic [2:0] mode;
  logic       inc_hr;
  logic       inc_min;
  logic       inc_al_hr;
  logic       inc_al_min;
  logic       clock_run;
  logic       alarm_en;
  logic [3:0] inc_vec;

  int   check_count = 0;
  int   pass_count  = 0;
  int   exp_mode    = 0;
  logic exp_alarm   = 1'b0;

  clock_mode_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_alarm  (btn_alarm),
    .mode       (mode),
    .inc_hr     (inc_hr),
    .inc_min    (inc_min),
    .inc_al_hr  (inc_al_hr),
    .inc_al_min (inc_al_min),
    .clock_run  (clock_run),
    .alarm_en   (alarm_en)
  );

  assign inc_vec = {inc_hr, inc_min, inc_al_hr, inc_al_min};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [3:0] field_vec(input int m);
    case (m)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic exp_run(input int m);
    return !((m == 1) || (m == 2));
  endfunction

  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
    exp_mode = (exp_mode + 1) % 5;
  endtask

  task automatic goto_mode(input int target);
    while (exp_mode != target) press_mode();
  endtask

  task automatic press_alarm(input int len);
    btn_alarm = 1'b1;
    repeat (len) @(negedge clk);
    btn_alarm = 1'b0;
    @(negedge clk);
    exp_alarm = ~exp_alarm;
  endtask

  task automatic test_reset();
    int hold;
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_alarm = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if ({mode, inc_vec, clock_run, alarm_en} !== {3'd0, 4'd0, 1'b1, 1'b0})
      $display("[TB] FAIL reset_state: got %b expected %b", {mode, inc_vec, clock_run, alarm_en}, {3'd0, 4'd0, 1'b1, 1'b0});
    else pass_count++;
    rst = 1'b0;
    @(negedge clk);
    exp_mode = 0;
    exp_alarm = 1'b0;
    press_alarm(1);
    goto_mode(2);
    btn_inc = 1'b1;
    hold = $urandom_range(3, 15);
    repeat (hold) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_count++;
    if ({mode, inc_vec, clock_run, alarm_en} !== {3'd0, 4'd0, 1'b1, 1'b0})
      $display("[TB] FAIL reset_async: got %b expected %b", {mode, inc_vec, clock_run, alarm_en}, {3'd0, 4'd0, 1'b1, 1'b0});
    else pass_count++;
    exp_mode = 0;
    exp_alarm = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t == 9) btn_inc = 1'b0;
      check_count++;
      if ({mode, inc_vec, alarm_en} !== {3'd0, 4'd0, 1'b0})
        $display("[TB] FAIL reset_after: cycle %0d got %b expected %b", t, {mode, inc_vec, alarm_en}, {3'd0, 4'd0, 1'b0});
      else pass_count++;
    end
    press_mode();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check_count++;
      if ({mode, inc_vec} !== {3'd1, 4'd0})
        $display("[TB] FAIL reset_no_stale_pulse: got %b expected %b", {mode, inc_vec}, {3'd1, 4'd0});
      else pass_count++;
    end
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    check_count++;
    if (inc_vec !== 4'b1000)
      $display("[TB] FAIL reset_new_press: got %b expected %b", inc_vec, 4'b1000);
    else pass_count++;
    goto_mode(0);
  endtask

  task automatic test_mode_cycle();
    int len;
    int gap;
    for (int i = 0; i < 5; i++) begin
      len = $urandom_range(1, 4);
      btn_mode = 1'b1;
      repeat (len) @(negedge clk);
      btn_mode = 1'b0;
      @(negedge clk);
      exp_mode = (exp_mode + 1) % 5;
      check_count++;
      if ({mode, clock_run} !== {3'(exp_mode), exp_run(exp_mode)})
        $display("[TB] FAIL mode_cycle: got mode=%0d run=%0b expected mode=%0d run=%0b", mode, clock_run, exp_mode, exp_run(exp_mode));
      else pass_count++;
      gap = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      check_count++;
      if (mode !== 3'(exp_mode))
        $display("[TB] FAIL mode_single_step: got %0d expected %0d", mode, exp_mode);
      else pass_count++;
    end
  endtask

  task automatic test_auto_repeat(input int target, input int len);
    logic       hit;
    logic [3:0] expv;
    goto_mode(target);
    btn_inc = 1'b1;
    for (int t = 0; t <= len + 8; t++) begin
      @(negedge clk);
      hit = (t == 1) ||
            ((t >= HOLD + 2) && (t <= len - 1) && (((t - (HOLD + 2)) % REP) == 0));
      expv = hit ? field_vec(target) : 4'b0000;
      check_count++;
      if ({mode, inc_vec} !== {3'(target), expv})
        $display("[TB] FAIL auto_repeat: mode %0d len %0d cycle %0d got %b/%b expected %0d/%b", target, len, t, mode, inc_vec, target, expv);
      else pass_count++;
      if (t == len - 1) btn_inc = 1'b0;
    end
    goto_mode(0);
  endtask

  task automatic test_run_ignore();
    int len;
    len = $urandom_range(10, 14);
    btn_inc = 1'b1;
    for (int t = 0; t <= len + 4; t++) begin
      @(negedge clk);
      check_count++;
      if ({mode, inc_vec} !== {3'd0, 4'd0})
        $display("[TB] FAIL run_ignore: cycle %0d got %b expected %b", t, {mode, inc_vec}, {3'd0, 4'd0});
      else pass_count++;
      if (t == len - 1) btn_inc = 1'b0;
    end
  endtask

  task automatic test_collision();
    goto_mode(4);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    check_count++;
    if ({mode, inc_vec} !== {3'd4, 4'd0})
      $display("[TB] FAIL collision_pre: got %b expected %b", {mode, inc_vec}, {3'd4, 4'd0});
    else pass_count++;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      exp_mode = 0;
      check_count++;
      if ({mode, inc_vec, clock_run} !== {3'd0, 4'd0, 1'b1})
        $display("[TB] FAIL collision: cycle %0d got %b expected %b", t, {mode, inc_vec, clock_run}, {3'd0, 4'd0, 1'b1});
      else pass_count++;
    end
  endtask

  task automatic test_alarm();
    press_alarm(1);
    check_count++;
    if ({mode, alarm_en} !== {3'd0, exp_alarm})
      $display("[TB] FAIL alarm_run: got %b expected %b", {mode, alarm_en}, {3'd0, exp_alarm});
    else pass_count++;
    goto_mode(3);
    press_alarm(1);
    check_count++;
    if ({mode, alarm_en} !== {3'd3, exp_alarm})
      $display("[TB] FAIL alarm_al_hr: got %b expected %b", {mode, alarm_en}, {3'd3, exp_alarm});
    else pass_count++;
    for (int i = 0; i < 4; i++) begin
      press_alarm($urandom_range(1, 3));
      check_count++;
      if ({mode, alarm_en} !== {3'd3, exp_alarm})
        $display("[TB] FAIL alarm_toggle: press %0d got %b expected %b", i, {mode, alarm_en}, {3'd3, exp_alarm});
      else pass_count++;
    end
    btn_alarm = 1'b1;
    btn_mode = 1'b1;
    @(negedge clk);
    btn_alarm = 1'b0;
    btn_mode = 1'b0;
    @(negedge clk);
    exp_alarm = ~exp_alarm;
    exp_mode = 4;
    check_count++;
    if ({mode, alarm_en} !== {3'd4, exp_alarm})
      $display("[TB] FAIL alarm_with_mode: got %b expected %b", {mode, alarm_en}, {3'd4, exp_alarm});
    else pass_count++;
    goto_mode(0);
  endtask

  task automatic test_timeout(input int c);
    int         ret;
    int         expm;
    logic [3:0] expv;
    goto_mode(2);
    ret = (c == 0) ? TMO : c + TMO;
    for (int j = 0; j <= ret + 3; j++) begin
      if (j > 0) @(negedge clk);
      expm = (j < ret) ? 2 : 0;
      expv = ((c != 0) && (j == c)) ? 4'b0100 : 4'b0000;
      check_count++;
      if ({mode, clock_run, inc_vec} !== {3'(expm), exp_run(expm), expv})
        $display("[TB] FAIL timeout: press %0d cycle %0d got %b expected %b", c, j, {mode, clock_run, inc_vec}, {3'(expm), exp_run(expm), expv});
      else pass_count++;
      if ((c != 0) && (j == c - 2)) btn_inc = 1'b1;
      if ((c != 0) && (j == c - 1)) btn_inc = 1'b0;
    end
    exp_mode = 0;
  endtask

  // Bounded run time so a stuck design still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence followed by the summary.
  initial begin
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_alarm = 1'b0;
    test_reset();
    test_mode_cycle();
    test_auto_repeat(1, 20);
    for (int i = 0; i < 4; i++) begin
      test_auto_repeat($urandom_range(1, 4), $urandom_range(1, 30));
    end
    test_run_ignore();
    test_collision();
    test_alarm();
    test_timeout(0);
    test_timeout(20);
    test_timeout($urandom_range(2, 30));
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
